timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 97 +++++++++
 tb/tb_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// Memory-mapped up-counter with three registers (STATUS, GOAL, CURR) on an APB-style bus.
// Counts from zero up to GOAL, then parks in COMPLETE; supports pause via the STOP bit.
module timer #(
  parameter int                   timerbits     = 8,
  parameter int                   addrWidth     = 32,
  parameter logic [addrWidth-1:0] timerBaseAddr = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 enable,
  input  logic                 write,
  input  logic [addrWidth-1:0] addr,
  input  logic [timerbits-1:0] wdata,
  output logic [timerbits-1:0] rdata,
  output logic                 ready,
  output logic                 slverr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t               state;
  logic                 start;
  logic                 stop;
  logic [timerbits-1:0] goal;
  logic [timerbits-1:0] curr;

  logic [addrWidth-1:0] offset;
  logic                 hit;
  logic                 wr_status;
  logic                 wr_goal;
  logic                 wr_curr;
  logic [timerbits-1:0] status_word;

  // Offset arithmetic keeps the window check a single unsigned compare.
  assign offset    = addr - timerBaseAddr;
  assign hit       = sel && (offset < addrWidth'(3));
  assign ready     = reset && sel && enable && hit;
  assign wr_status = ready && write && (offset == addrWidth'(0));
  assign wr_goal   = ready && write && (offset == addrWidth'(1));
  assign wr_curr   = ready && write && (offset == addrWidth'(2));
  assign slverr    = wr_curr || (wr_goal && (state == RUNNING));

  assign status_word = {{(timerbits-4){1'b0}}, state, stop, start};

  always_comb begin
    rdata = '0;
    if (ready && !write) begin
      case (offset[1:0])
        2'd0:    rdata = status_word;
        2'd1:    rdata = goal;
        2'd2:    rdata = curr;
        default: rdata = '0;
      endcase
    end
  end

  // Bus writes take precedence over the counting step on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      start <= 1'b0;
      stop  <= 1'b0;
      goal  <= '0;
      curr  <= '0;
    end else if (wr_status) begin
      stop <= wdata[1];
      if (!wdata[0]) begin
        state <= IDLE;
        start <= 1'b0;
        curr  <= '0;
      end else if (state == RUNNING) begin
        start <= 1'b1;
      end else begin
        state <= RUNNING;
        start <= 1'b1;
        curr  <= '0;
      end
    end else if (wr_goal) begin
      if (state != RUNNING) begin
        goal <= wdata;
      end
    end else if (state == RUNNING && !stop) begin
      // Equality stop means CURR never wraps, and GOAL=0 completes immediately.
      if (curr == goal) begin
        state <= COMPLETE;
      end else begin
        curr <= curr + timerbits'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for timer: register access, window decoding, run, pause, errors, reset.
module tb_timer;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        enable;
  logic        write;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        slverr;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] obs_rdata;
  logic       obs_ready;
  logic       obs_slverr;
  logic [7:0] held_curr;

  timer #(.timerbits(8), .addrWidth(32), .timerBaseAddr(32'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .enable (enable),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .slverr (slverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access: drive on the falling edge, sample mid-cycle, commit on the rising edge.
  task automatic applyStimulus(input logic s, input logic en, input logic wr,
                               input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    sel    = s;
    enable = en;
    write  = wr;
    addr   = a;
    wdata  = d;
    #1;
    obs_rdata  = rdata;
    obs_ready  = ready;
    obs_slverr = slverr;
    @(posedge clk);
    #1;
    sel    = 1'b0;
    enable = 1'b0;
    write  = 1'b0;
    addr   = '0;
    wdata  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic doRead(input logic [31:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  initial begin
    reset  = 1'b0;
    sel    = 1'b1;
    enable = 1'b1;
    write  = 1'b0;
    addr   = 32'd0;
    wdata  = 8'h00;
    #12;
    checkOutput("reset_ready", {7'd0, ready}, 8'h00);
    checkOutput("reset_rdata", rdata, 8'h00);
    checkOutput("reset_slverr", {7'd0, slverr}, 8'h00);
    sel    = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");

    doRead(32'd0);
    checkOutput("status_after_reset", obs_rdata, 8'h00);
    checkOutput("read_ready", {7'd0, obs_ready}, 8'h01);
    doRead(32'd1);
    checkOutput("goal_after_reset", obs_rdata, 8'h00);
    doRead(32'd2);
    checkOutput("curr_after_reset", obs_rdata, 8'h00);

    // Out-of-window address.
    doWrite(32'd3, 8'h55);
    checkOutput("oow_wr_ready", {7'd0, obs_ready}, 8'h00);
    checkOutput("oow_wr_slverr", {7'd0, obs_slverr}, 8'h00);
    doRead(32'd3);
    checkOutput("oow_rd_ready", {7'd0, obs_ready}, 8'h00);
    checkOutput("oow_rd_rdata", obs_rdata, 8'h00);
    doRead(32'd1);
    checkOutput("goal_after_oow", obs_rdata, 8'h00);
    doRead(32'd0);
    checkOutput("status_after_oow", obs_rdata, 8'h00);

    // Unselected access.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd0, 8'h01);
    checkOutput("nosel_wr_ready", {7'd0, obs_ready}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 8'h00);
    checkOutput("nosel_rd_ready", {7'd0, obs_ready}, 8'h00);
    checkOutput("nosel_rd_rdata", obs_rdata, 8'h00);
    doRead(32'd0);
    checkOutput("status_after_nosel", obs_rdata, 8'h00);

    // Run to completion with GOAL=25.
    doWrite(32'd1, 8'd25);
    checkOutput("goal_wr_idle_slverr", {7'd0, obs_slverr}, 8'h00);
    checkOutput("goal_wr_ready", {7'd0, obs_ready}, 8'h01);
    doWrite(32'd0, 8'h01);
    @(posedge clk);
    doRead(32'd2);
    checkOutput("curr_running", obs_rdata, 8'd1);
    doRead(32'd0);
    checkOutput("status_running", obs_rdata, 8'h05);
    repeat (30) @(posedge clk);
    doRead(32'd0);
    checkOutput("status_complete", obs_rdata, 8'h09);
    doRead(32'd2);
    checkOutput("curr_complete", obs_rdata, 8'd25);
    checkOutput("read_slverr", {7'd0, obs_slverr}, 8'h00);

    // Pause: start, let it count, then set STOP.
    doWrite(32'd0, 8'h00);
    doRead(32'd0);
    checkOutput("status_idle", obs_rdata, 8'h00);
    doWrite(32'd1, 8'd100);
    doWrite(32'd0, 8'h01);
    repeat (2) @(posedge clk);
    doWrite(32'd0, 8'h03);
    doRead(32'd2);
    held_curr = obs_rdata;
    checkOutput("pause_curr_nonzero", {7'd0, (held_curr != 8'd0)}, 8'h01);
    repeat (3) @(posedge clk);
    doRead(32'd2);
    checkOutput("pause_curr_held", obs_rdata, held_curr);
    doRead(32'd0);
    checkOutput("status_paused", obs_rdata, 8'h07);

    // Illegal writes.
    doWrite(32'd2, 8'hAA);
    checkOutput("curr_wr_slverr", {7'd0, obs_slverr}, 8'h01);
    doRead(32'd2);
    checkOutput("curr_after_wr", obs_rdata, held_curr);
    doWrite(32'd1, 8'd50);
    checkOutput("goal_wr_run_slverr", {7'd0, obs_slverr}, 8'h01);
    doRead(32'd1);
    checkOutput("goal_unchanged", obs_rdata, 8'd100);

    // Resume counting.
    doWrite(32'd0, 8'h01);
    repeat (4) @(posedge clk);
    doRead(32'd2);
    checkOutput("resume_counts", {7'd0, (obs_rdata > held_curr)}, 8'h01);

    // GOAL=0 completes right after start.
    doWrite(32'd0, 8'h00);
    doWrite(32'd1, 8'd0);
    doWrite(32'd0, 8'h01);
    @(posedge clk);
    doRead(32'd0);
    checkOutput("goal0_status", obs_rdata, 8'h09);
    doRead(32'd2);
    checkOutput("goal0_curr", obs_rdata, 8'd0);

    // High STATUS bits ignored; then abort by reset mid-count.
    doWrite(32'd1, 8'd200);
    checkOutput("goal_wr_complete_slverr", {7'd0, obs_slverr}, 8'h00);
    doWrite(32'd0, 8'hFD);
    doRead(32'd0);
    checkOutput("status_high_bits", obs_rdata, 8'h05);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_ready", {7'd0, ready}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    doRead(32'd0);
    checkOutput("status_after_abort", obs_rdata, 8'h00);
    doRead(32'd2);
    checkOutput("curr_after_abort", obs_rdata, 8'h00);
    doRead(32'd1);
    checkOutput("goal_after_abort", obs_rdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
